conv_kernel_ctrl: RTL and testbench

Controller that sequences one conv tile through the 4-lane convolution data path: 4 MACs per cycle feeding an adder tree and accumulator. It issues input-feature and weight buffer reads, pulses kernel_start at the first operand of each output pixel, and schedules the out_fm read-modify-write that folds each pixel's accumulated sum into the output buffer. It sits between the tile loader/scheduler (start/done) and the on-chip buffers plus data path.

---
 rtl/conv_kernel_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_conv_kernel_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_kernel_ctrl.sv
// Sequencer for one conv tile through the 4-lane MAC data path.
// Issues operand reads, kernel_start, and the out_fm read-modify-write schedule.
module conv_kernel_ctrl #(
    parameter int K       = 3,
    parameter int ROW_W   = 6,
    parameter int COL_W   = 6,
    parameter int CG_W    = 6,
    parameter int IN_AW   = 16,
    parameter int W_AW    = 12,
    parameter int OUT_AW  = 12,
    parameter int RD_LAT  = 1,
    parameter int ACC_LAT = 51,
    parameter int ADD_LAT = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  cfg_tr,
    input  logic [COL_W-1:0]  cfg_tc,
    input  logic [CG_W-1:0]   cfg_cg,
    output logic              busy,
    output logic              done,
    output logic              in_fm_rd_ena,
    output logic [IN_AW-1:0]  in_fm_rd_addr,
    output logic              weight_rd_ena,
    output logic [W_AW-1:0]   weight_rd_addr,
    output logic              kernel_start,
    output logic              out_fm_rd_ena,
    output logic [OUT_AW-1:0] out_fm_rd_addr,
    output logic              out_fm_wr_ena,
    output logic [OUT_AW-1:0] out_fm_wr_addr
);

    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int WD = RD_LAT + ADD_LAT;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state;
    logic [ROW_W-1:0]  tr_q, r, n_r;
    logic [COL_W-1:0]  tc_q, c, n_c;
    logic [CG_W-1:0]   cg_q, g, n_g;
    logic [KW-1:0]     kr, kc, n_kr, n_kc;

    logic wrap_kc, wrap_kr, wrap_g, wrap_c, wrap_r;
    logic last_op, pix_first, pix_last, zero_cfg, wr_last;

    logic [IN_AW-1:0]  in_cols, in_rows, plane, in_addr_n;
    logic [W_AW-1:0]   w_addr_n;
    logic [OUT_AW-1:0] pix_p;

    logic [RD_LAT-1:0]  ks_v;
    logic [ACC_LAT-1:0] rv;
    logic [OUT_AW-1:0]  rp [ACC_LAT];
    logic [WD-1:0]      wv;
    logic [OUT_AW-1:0]  wp [WD];

    assign zero_cfg = (cfg_tr == '0) || (cfg_tc == '0) || (cfg_cg == '0);

    assign wrap_kc = (kc == KW'(K - 1));
    assign wrap_kr = (kr == KW'(K - 1));
    assign wrap_g  = (g == cg_q - 1'b1);
    assign wrap_c  = (c == tc_q - 1'b1);
    assign wrap_r  = (r == tr_q - 1'b1);

    assign pix_first = (kc == '0) && (kr == '0) && (g == '0);
    assign pix_last  = wrap_kc && wrap_kr && wrap_g;
    assign last_op   = pix_last && wrap_c && wrap_r;

    assign in_cols = IN_AW'(tc_q) + IN_AW'(K - 1);
    assign in_rows = IN_AW'(tr_q) + IN_AW'(K - 1);
    assign plane   = in_rows * in_cols;

    assign in_addr_n = IN_AW'(n_g) * plane
                     + (IN_AW'(n_r) + IN_AW'(n_kr)) * in_cols
                     + IN_AW'(n_c) + IN_AW'(n_kc);
    assign w_addr_n  = W_AW'(n_g) * W_AW'(K * K)
                     + W_AW'(n_kr) * W_AW'(K) + W_AW'(n_kc);
    assign pix_p     = OUT_AW'(r) * OUT_AW'(tc_q) + OUT_AW'(c);

    // Odometer over r,c,g,kr,kc; yields the operand after the current one.
    always_comb begin
        n_kc = '0;
        n_kr = '0;
        n_g  = '0;
        n_c  = '0;
        n_r  = '0;
        if (state == ISSUE) begin
            n_kc = wrap_kc ? '0 : kc + 1'b1;
            n_kr = kr;
            n_g  = g;
            n_c  = c;
            n_r  = r;
            if (wrap_kc) begin
                n_kr = wrap_kr ? '0 : kr + 1'b1;
                if (wrap_kr) begin
                    n_g = wrap_g ? '0 : g + 1'b1;
                    if (wrap_g) begin
                        n_c = wrap_c ? '0 : c + 1'b1;
                        if (wrap_c) n_r = r + 1'b1;
                    end
                end
            end
        end
    end

    assign wr_last = wv[WD-1] && (rv == '0)
                  && ((wv & ~(WD'(1) << (WD - 1))) == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            tr_q           <= '0;
            tc_q           <= '0;
            cg_q           <= '0;
            r              <= '0;
            c              <= '0;
            g              <= '0;
            kr             <= '0;
            kc             <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            in_fm_rd_ena   <= 1'b0;
            weight_rd_ena  <= 1'b0;
            in_fm_rd_addr  <= '0;
            weight_rd_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tr_q <= cfg_tr;
                        tc_q <= cfg_tc;
                        cg_q <= cfg_cg;
                        r    <= '0;
                        c    <= '0;
                        g    <= '0;
                        kr   <= '0;
                        kc   <= '0;
                        if (zero_cfg) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state          <= ISSUE;
                            busy           <= 1'b1;
                            in_fm_rd_ena   <= 1'b1;
                            weight_rd_ena  <= 1'b1;
                            in_fm_rd_addr  <= '0;
                            weight_rd_addr <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (last_op) begin
                        state          <= DRAIN;
                        in_fm_rd_ena   <= 1'b0;
                        weight_rd_ena  <= 1'b0;
                        in_fm_rd_addr  <= '0;
                        weight_rd_addr <= '0;
                    end else begin
                        r              <= n_r;
                        c              <= n_c;
                        g              <= n_g;
                        kr             <= n_kr;
                        kc             <= n_kc;
                        in_fm_rd_addr  <= in_addr_n;
                        weight_rd_addr <= w_addr_n;
                    end
                end
                DRAIN: begin
                    if (wr_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pixel events ride delay lines carrying P; idle slots hold address 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ks_v <= '0;
            rv   <= '0;
            wv   <= '0;
            for (int i = 0; i < ACC_LAT; i++) rp[i] <= '0;
            for (int i = 0; i < WD; i++) wp[i] <= '0;
        end else begin
            ks_v[0] <= in_fm_rd_ena && pix_first;
            for (int i = 1; i < RD_LAT; i++) ks_v[i] <= ks_v[i-1];
            rv[0] <= in_fm_rd_ena && pix_last;
            rp[0] <= (in_fm_rd_ena && pix_last) ? pix_p : '0;
            for (int i = 1; i < ACC_LAT; i++) begin
                rv[i] <= rv[i-1];
                rp[i] <= rp[i-1];
            end
            wv[0] <= rv[ACC_LAT-1];
            wp[0] <= rp[ACC_LAT-1];
            for (int i = 1; i < WD; i++) begin
                wv[i] <= wv[i-1];
                wp[i] <= wp[i-1];
            end
        end
    end

    assign kernel_start   = ks_v[RD_LAT-1];
    assign out_fm_rd_ena  = rv[ACC_LAT-1];
    assign out_fm_rd_addr = rp[ACC_LAT-1];
    assign out_fm_wr_ena  = wv[WD-1];
    assign out_fm_wr_addr = wp[WD-1];

endmodule

// File: tb/tb_conv_kernel_ctrl.sv
// Bench for conv_kernel_ctrl: per-cycle trace compared with a loop-nest model.
// Covers K=3 and K=1 instances, ignored starts, mid-run reset, zero configs.
module tb_conv_kernel_ctrl;

    localparam int RDL  = 1;
    localparam int ACL  = 51;
    localparam int ADL  = 14;
    localparam int MAXC = 1024;

    logic clk = 1'b0;
    logic rst, st3, st1;
    logic [5:0] tr, tc, cg;

    logic b3, dn3, ie3, we3, ks3, re3, wr3;
    logic [15:0] ia3;
    logic [11:0] wa3, ra3, wra3;
    logic b1, dn1, ie1, we1, ks1, re1, wr1;
    logic [15:0] ia1;
    logic [11:0] wa1, ra1, wra1;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        in_en;
        logic [15:0] in_a;
        logic        w_en;
        logic [11:0] w_a;
        logic        ks;
        logic        rd_en;
        logic [11:0] rd_a;
        logic        wr_en;
        logic [11:0] wr_a;
    } obs_t;

    obs_t exp_t [MAXC];
    obs_t o3, o1, obs;
    bit   use1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    conv_kernel_ctrl dut3 (
        .clk(clk), .rst(rst), .start(st3),
        .cfg_tr(tr), .cfg_tc(tc), .cfg_cg(cg),
        .busy(b3), .done(dn3),
        .in_fm_rd_ena(ie3), .in_fm_rd_addr(ia3),
        .weight_rd_ena(we3), .weight_rd_addr(wa3),
        .kernel_start(ks3),
        .out_fm_rd_ena(re3), .out_fm_rd_addr(ra3),
        .out_fm_wr_ena(wr3), .out_fm_wr_addr(wra3)
    );

    conv_kernel_ctrl #(.K(1)) dut1 (
        .clk(clk), .rst(rst), .start(st1),
        .cfg_tr(tr), .cfg_tc(tc), .cfg_cg(cg),
        .busy(b1), .done(dn1),
        .in_fm_rd_ena(ie1), .in_fm_rd_addr(ia1),
        .weight_rd_ena(we1), .weight_rd_addr(wa1),
        .kernel_start(ks1),
        .out_fm_rd_ena(re1), .out_fm_rd_addr(ra1),
        .out_fm_wr_ena(wr1), .out_fm_wr_addr(wra1)
    );

    always_comb begin
        o3       = '0;
        o3.busy  = b3;
        o3.done  = dn3;
        o3.in_en = ie3;
        o3.in_a  = ie3 ? ia3 : '0;
        o3.w_en  = we3;
        o3.w_a   = we3 ? wa3 : '0;
        o3.ks    = ks3;
        o3.rd_en = re3;
        o3.rd_a  = re3 ? ra3 : '0;
        o3.wr_en = wr3;
        o3.wr_a  = wr3 ? wra3 : '0;
        o1       = '0;
        o1.busy  = b1;
        o1.done  = dn1;
        o1.in_en = ie1;
        o1.in_a  = ie1 ? ia1 : '0;
        o1.w_en  = we1;
        o1.w_a   = we1 ? wa1 : '0;
        o1.ks    = ks1;
        o1.rd_en = re1;
        o1.rd_a  = re1 ? ra1 : '0;
        o1.wr_en = wr1;
        o1.wr_a  = wr1 ? wra1 : '0;
    end

    assign obs = use1 ? o1 : o3;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Expected trace straight from the loop nest and latency rules.
    task automatic build(input int ntr, input int ntc, input int ncg,
                         input int k, output int n);
        int t, lw, ic, ir, p;
        for (int i = 0; i < MAXC; i++) exp_t[i] = '0;
        if (ntr == 0 || ntc == 0 || ncg == 0) begin
            exp_t[1].done = 1'b1;
            n = 4;
            return;
        end
        t  = 1;
        lw = 0;
        ic = ntc + k - 1;
        ir = ntr + k - 1;
        for (int r = 0; r < ntr; r++)
        for (int c = 0; c < ntc; c++)
        for (int g = 0; g < ncg; g++)
        for (int kr = 0; kr < k; kr++)
        for (int kc = 0; kc < k; kc++) begin
            exp_t[t].in_en = 1'b1;
            exp_t[t].in_a  = 16'(g*ir*ic + (r+kr)*ic + c + kc);
            exp_t[t].w_en  = 1'b1;
            exp_t[t].w_a   = 12'(g*k*k + kr*k + kc);
            if (g == 0 && kr == 0 && kc == 0) exp_t[t+RDL].ks = 1'b1;
            if (g == ncg-1 && kr == k-1 && kc == k-1) begin
                p = r*ntc + c;
                exp_t[t+ACL].rd_en = 1'b1;
                exp_t[t+ACL].rd_a  = 12'(p);
                lw = t + RDL + ACL + ADL;
                exp_t[lw].wr_en = 1'b1;
                exp_t[lw].wr_a  = 12'(p);
            end
            t++;
        end
        for (int i = 1; i <= lw; i++) exp_t[i].busy = 1'b1;
        exp_t[lw+1].done = 1'b1;
        n = lw + 3;
    endtask

    task automatic run(input int ntr, input int ntc, input int ncg,
                       input bit k1, input bit inj, input int rst_at);
        int n;
        build(ntr, ntc, ncg, k1 ? 1 : 3, n);
        use1 = k1;
        @(negedge clk);
        tr = 6'(ntr);
        tc = 6'(ntc);
        cg = 6'(ncg);
        if (k1) st1 = 1'b1;
        else st3 = 1'b1;
        for (int t = 1; t <= n; t++) begin
            @(negedge clk);
            st1 = 1'b0;
            st3 = 1'b0;
            if (t == rst_at) begin
                rst = 1'b0;
                #1;
                chk("rst_now", 64'(obs), 64'(0));
                break;
            end
            if (inj && (t == 5 || t == 40)) begin
                tc = 6'd9;
                if (k1) st1 = 1'b1;
                else st3 = 1'b1;
            end
            chk($sformatf("cyc%0d", t), 64'(obs), 64'(exp_t[t]));
        end
        st1 = 1'b0;
        st3 = 1'b0;
        if (rst_at > 0) begin
            for (int t = 0; t < 3; t++) begin
                @(negedge clk);
                chk("in_rst", 64'(obs), 64'(0));
            end
            rst = 1'b1;
            for (int t = 0; t < 120; t++) begin
                @(negedge clk);
                chk("post_rst", 64'(obs), 64'(0));
            end
        end
    endtask

    initial begin
        rst  = 1'b0;
        st3  = 1'b0;
        st1  = 1'b0;
        tr   = '0;
        tc   = '0;
        cg   = '0;
        use1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset3", 64'(o3), 64'(0));
        chk("reset1", 64'(o1), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        run(1, 1, 1, 1'b0, 1'b0, 0);
        run(1, 2, 2, 1'b0, 1'b0, 0);
        run(2, 2, 1, 1'b1, 1'b0, 0);
        run(1, 1, 1, 1'b0, 1'b1, 0);
        run(1, 2, 2, 1'b0, 1'b0, 30);
        run(1, 1, 1, 1'b0, 1'b0, 0);
        run(3, 2, 0, 1'b0, 1'b0, 0);
        run(0, 2, 1, 1'b1, 1'b0, 0);
        repeat (10) begin
            run($urandom_range(1, 3), $urandom_range(1, 3),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                1'b0, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
